// File: rtl/set_assoc_tag_mem.sv
// N-way set-associative tag store: parallel hit detection, victim selection and flush sweep.
// Replacement is round-robin by default; define TAG_MEM_PLRU_EN for per-set tree pseudo-LRU.
module set_assoc_tag_mem #(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 4,
   parameter int TAG_W    = 20,
   localparam int IDX_W   = $clog2(NUM_SETS),
   localparam int WAY_W   = $clog2(NUM_WAYS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             lookup_en_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             hit_o,
   output logic [WAY_W-1:0] hit_way_o,
   output logic [WAY_W-1:0] victim_way_o,
   output logic             victim_valid_o,
   output logic             victim_dirty_o,
   output logic [TAG_W-1:0] victim_tag_o,
   input  logic             fill_en_i,
   input  logic [WAY_W-1:0] fill_way_i,
   input  logic [TAG_W-1:0] fill_tag_i,
   input  logic             fill_dirty_i,
   input  logic             mark_dirty_en_i,
   input  logic [WAY_W-1:0] mark_way_i,
   input  logic             flush_req_i,
   output logic             flush_busy_o,
   output logic             flush_done_o,
   output logic [1:0]       flush_state_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} flush_state_t;

   flush_state_t      state_q;
   logic [IDX_W-1:0]  sweep_cnt_q;
   logic              busy_q;
   logic              done_q;

   logic [TAG_W-1:0]    tag_mem [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
   logic [WAY_W-1:0]    repl_way;
   logic                inv_found;
   logic [WAY_W-1:0]    inv_way;

   assign flush_busy_o  = busy_q;
   assign flush_done_o  = done_q;
   assign flush_state_o = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         sweep_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (flush_req_i) begin
                  state_q     <= ST_SWEEP;
                  sweep_cnt_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            ST_SWEEP: begin
               sweep_cnt_q <= sweep_cnt_q + 1'b1;
               if (sweep_cnt_q == IDX_W'(NUM_SETS - 1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Fill is written after the dirty mark so a fill to the same way wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else if (state_q == ST_SWEEP) begin
         valid_q[sweep_cnt_q] <= '0;
         dirty_q[sweep_cnt_q] <= '0;
      end else if (!busy_q) begin
         if (mark_dirty_en_i && valid_q[index_i][mark_way_i])
            dirty_q[index_i][mark_way_i] <= 1'b1;
         if (fill_en_i) begin
            valid_q[index_i][fill_way_i] <= 1'b1;
            dirty_q[index_i][fill_way_i] <= fill_dirty_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_en_i && !busy_q)
         tag_mem[index_i][fill_way_i] <= fill_tag_i;
   end

   always_comb begin
      hit_o     = 1'b0;
      hit_way_o = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[index_i][w] && (tag_mem[index_i][w] == tag_i)) begin
            hit_o     = 1'b1;
            hit_way_o = WAY_W'(w);
         end
      end
      if (busy_q) begin
         hit_o     = 1'b0;
         hit_way_o = '0;
      end
   end

`ifdef TAG_MEM_PLRU_EN
   // Tree nodes are heap-numbered from 1; a node bit of 1 steers the victim walk right.
   logic [NUM_WAYS-1:1] plru_q [NUM_SETS];

   function automatic logic [NUM_WAYS-1:1] plru_touch(input logic [NUM_WAYS-1:1] bits,
                                                       input logic [WAY_W-1:0] way);
      logic [NUM_WAYS-1:1] b;
      logic [WAY_W-1:0]    node;
      logic [WAY_W-1:0]    w;
      logic                dir;
      b    = bits;
      node = WAY_W'(1);
      w    = way;
      for (int l = 0; l < WAY_W; l++) begin
         dir     = w[WAY_W-1];
         b[node] = ~dir;
         node    = (node << 1) + WAY_W'(dir);
         w       = w << 1;
      end
      return b;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-1:1] bits);
      logic [WAY_W-1:0] node;
      logic [WAY_W-1:0] v;
      logic             dir;
      node = WAY_W'(1);
      v    = '0;
      for (int l = 0; l < WAY_W; l++) begin
         dir  = bits[node];
         v    = (v << 1) + WAY_W'(dir);
         node = (node << 1) + WAY_W'(dir);
      end
      return v;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
      end else if (!busy_q) begin
         if (fill_en_i)
            plru_q[index_i] <= plru_touch(plru_q[index_i], fill_way_i);
         else if (lookup_en_i && hit_o)
            plru_q[index_i] <= plru_touch(plru_q[index_i], hit_way_o);
      end
   end

   assign repl_way = plru_victim(plru_q[index_i]);
`else
   logic [WAY_W-1:0] rr_q [NUM_SETS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else if (!busy_q && fill_en_i) begin
         rr_q[index_i] <= rr_q[index_i] + 1'b1;
      end
   end

   assign repl_way = rr_q[index_i];
`endif

   // Invalid ways are always preferred over the replacement choice.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[index_i][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim_way_o   = inv_found ? inv_way : repl_way;
   assign victim_valid_o = valid_q[index_i][victim_way_o];
   assign victim_dirty_o = valid_q[index_i][victim_way_o] & dirty_q[index_i][victim_way_o];
   assign victim_tag_o   = tag_mem[index_i][victim_way_o];

endmodule

// File: doc/set_assoc_tag_mem.md
Name: set_assoc_tag_mem

Overview:
- N-way set-associative L1 data cache tag store. Generalises the direct-mapped tag memory with:
  - per-way valid and dirty bits,
  - parallel hit detection,
  - victim selection with per-set replacement state,
  - a multi-cycle flush sequencer.
- Sits between the cache controller FSM and the data arrays. The controller issues lookups, fills, dirty marks and flushes; this block returns hit way, victim way and victim writeback info.

Parameters:
- NUM_SETS, 64, number of sets; power of 2, ≥2; IDX_W = $clog2(NUM_SETS).
- NUM_WAYS, 4, associativity; power of 2, ≥2; WAY_W = $clog2(NUM_WAYS).
- TAG_W, 20, tag width in bits.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- lookup_en_i  in  1  lookup request this cycle; updates replacement state on hit.
- index_i  in  IDX_W  set index for lookup, fill and dirty-mark.
- tag_i  in  TAG_W  tag compared in lookup.
- hit_o  out  1  combinational; tag match on a valid way.
- hit_way_o  out  WAY_W  matching way; 0 when no hit.
- victim_way_o  out  WAY_W  way to replace in set index_i.
- victim_valid_o  out  1  victim way currently valid.
- victim_dirty_o  out  1  victim way valid and dirty; writeback needed.
- victim_tag_o  out  TAG_W  stored tag of the victim way.
- fill_en_i  in  1  write fill_tag_i into (index_i, fill_way_i); sets valid, dirty=fill_dirty_i.
- fill_way_i  in  WAY_W  fill target way.
- fill_tag_i  in  TAG_W  fill tag.
- fill_dirty_i  in  1  initial dirty bit for fill (write-allocate store).
- mark_dirty_en_i  in  1  set dirty for (index_i, mark_way_i) if valid.
- mark_way_i  in  WAY_W  dirty-mark target.
- flush_req_i  in  1  start invalidate-all sweep.
- flush_busy_o  out  1  sweep in progress.
- flush_done_o  out  1  one-cycle pulse when sweep completes.

Behaviour:
- Storage:
  - Tag array: read asynchronous, write synchronous.
  - Valid, dirty and replacement state: flops, so reset can clear them.
- Reset: all valid=0, dirty=0, replacement state=0, FSM=IDLE.
  - Output values after reset: hit_o=0, hit_way_o=0, flush_busy_o=0, flush_done_o=0, victim_way_o=0, victim_valid_o=0, victim_dirty_o=0.
  - victim_tag_o is don't-care.
- Lookup is combinational, zero latency. Compares all ways of set index_i in parallel.
  - Multiple matches are illegal (the controller never fills a duplicate); hit_way_o = lowest matching way.
- Victim select, combinational:
  - Lowest-indexed invalid way if any.
  - Otherwise the replacement pointer/tree of set index_i.
- Replacement state update at posedge:
  - On lookup_en_i & hit_o: touch hit_way_o.
  - On fill_en_i: touch fill_way_i.
  - Fill takes priority when both occur.
- Write ordering: all outputs in a cycle reflect pre-edge state. A fill and a lookup in the same cycle see old contents.
- fill_en_i with mark_dirty_en_i to the same way: fill wins, so dirty=fill_dirty_i.
- Flush FSM:
  - IDLE: flush_req_i → SWEEP, counter=0.
  - SWEEP: each cycle clears valid and dirty of set[counter] in all ways; counter++. At counter==NUM_SETS-1 → DONE.
  - DONE: flush_done_o=1 for one cycle → IDLE.
  - Flush takes exactly NUM_SETS+1 cycles after the request edge.
  - flush_busy_o=1 in SWEEP and DONE.
  - While busy: hit_o forced 0; fill_en_i, mark_dirty_en_i and lookup replacement updates are ignored; flush_req_i is ignored.
- Flush does not write back dirty lines. The controller drains them beforehand.
- rst_i mid-flush: FSM → IDLE, all state cleared, no flush_done_o pulse.

Optional Feature:
- Macro TAG_MEM_PLRU_EN.
- Defined: per-set tree pseudo-LRU of NUM_WAYS-1 bits.
  - Touch sets the tree bits to point away from the accessed way.
  - Victim = the leaf the tree bits point to.
- Undefined: per-set WAY_W-bit round-robin pointer.
  - Advances by 1 mod NUM_WAYS on fill only; hits do not touch it.
  - Victim = pointer.

Test Plan:
- Reset, then lookup index 5, tag 0x123 → hit_o=0, victim_way_o=0, victim_valid_o=0.
- Fill ways 0..3 of set 5 with tags 0xA..0xD, then lookup tag 0xC → hit_o=1, hit_way_o=2; lookup tag 0xE → hit_o=0, victim_valid_o=1.
- Fill set 5 way 1 with fill_dirty_i=0, mark_dirty way 1, fill remaining ways so the victim becomes way 1 → victim_dirty_o=1, victim_tag_o=way-1 tag.
- PLRU defined: after filling ways 0-3, hit ways 0, 2, 1 → victim_way_o=3. Round-robin build: after 4 fills the victim is 0 regardless of hits.
- Fill several sets, pulse flush_req_i, drive fill_en_i during the sweep → flush_busy_o high for NUM_SETS+1 cycles, flush_done_o pulse on the last cycle, mid-sweep fill has no effect, every lookup then misses.
- Assert rst_i at sweep cycle 10 → flush_busy_o=0 next cycle, no flush_done_o pulse, all lookups miss.
